// File: rtl/ctl_shot_multi.sv
// rtl/ctl_shot_multi.sv - shot resolution for N ducks: mouse box test or light-gun blank/flash sequence
// Resolves each accepted shot to at most one target (lowest index wins) and tracks per-round ammo.
module ctl_shot_multi #(
  parameter int N_TARGETS       = 2,
  parameter int TARGET_WIDTH    = 64,
  parameter int TARGET_HEIGHT   = 48,
  parameter int SHOTS_PER_ROUND = 3,
  parameter int IDX_W           = (N_TARGETS > 1) ? $clog2(N_TARGETS) : 1
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_new_frame,
  input  logic                    i_round_start,
  input  logic                    i_gun_is_connected,
  input  logic                    i_gun_trigger,
  input  logic                    i_gun_photodetector,
  input  logic                    i_mouse_left,
  input  logic [9:0]              i_mouse_x,
  input  logic [9:0]              i_mouse_y,
  input  logic [N_TARGETS*10-1:0] i_target_x,
  input  logic [N_TARGETS*10-1:0] i_target_y,
  input  logic [N_TARGETS-1:0]    i_target_active,
  output logic                    o_blank_screen,
  output logic                    o_flash_en,
  output logic [IDX_W-1:0]        o_flash_idx,
  output logic                    o_busy,
  output logic                    o_shot_fired,
  output logic                    o_hit,
  output logic                    o_miss,
  output logic [IDX_W-1:0]        o_hit_idx,
  output logic [2:0]              o_shots_left
);

  typedef enum logic [2:0] {S_IDLE, S_M_EVAL, S_G_WAIT, S_G_BLANK, S_G_FLASH, S_RESULT} state_t;

  state_t                  r_state, w_state_nxt;
  logic                    r_trig_s1, r_trig_s2, r_trig_d;
  logic                    r_photo_s1, r_photo_s2, r_photo_seen;
  logic                    r_mouse_d, r_shot_fired, r_res_hit;
  logic [2:0]              r_shots_left;
  logic [IDX_W-1:0]        r_flash_idx, r_hit_idx;
  logic [9:0]              r_mx, r_my;
  logic [N_TARGETS*10-1:0] r_tx, r_ty;
  logic [N_TARGETS-1:0]    r_tact;

  logic                    w_shot_edge, w_accept, w_photo_any;
  logic                    w_m_any, w_first_any, w_next_any;
  logic [IDX_W-1:0]        w_m_idx, w_first_idx, w_next_idx;
  logic                    w_enter_result, w_res_hit, w_flash_load;
  logic [IDX_W-1:0]        w_res_idx, w_flash_nxt;

  // 11-bit compare so a box near the right/bottom edge cannot wrap past 1023
  function automatic logic in_box(input logic [9:0] px, input logic [9:0] py,
                                  input logic [9:0] tx, input logic [9:0] ty);
    logic [10:0] x, y, bx, by;
    x  = {1'b0, px};
    y  = {1'b0, py};
    bx = {1'b0, tx};
    by = {1'b0, ty};
    return (x >= bx) && (x < bx + 11'(TARGET_WIDTH)) &&
           (y >= by) && (y < by + 11'(TARGET_HEIGHT));
  endfunction

  assign w_shot_edge = i_gun_is_connected ? (r_trig_s2 & ~r_trig_d) : (i_mouse_left & ~r_mouse_d);
  assign w_accept    = w_shot_edge && (r_state == S_IDLE) && (r_shots_left != 3'd0) && !i_round_start;
  assign w_photo_any = r_photo_seen | r_photo_s2;

  // Descending scans leave the lowest matching index in each result
  always_comb begin
    w_m_any     = 1'b0;
    w_m_idx     = '0;
    w_first_any = 1'b0;
    w_first_idx = '0;
    w_next_any  = 1'b0;
    w_next_idx  = '0;
    for (int i = N_TARGETS - 1; i >= 0; i--) begin
      if (r_tact[i] && in_box(r_mx, r_my, r_tx[10*i +: 10], r_ty[10*i +: 10])) begin
        w_m_any = 1'b1;
        w_m_idx = IDX_W'(i);
      end
      if (i_target_active[i]) begin
        w_first_any = 1'b1;
        w_first_idx = IDX_W'(i);
      end
      if (i_target_active[i] && (IDX_W'(i) > r_flash_idx)) begin
        w_next_any = 1'b1;
        w_next_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_enter_result = 1'b0;
    w_res_hit      = 1'b0;
    w_res_idx      = r_hit_idx;
    w_flash_load   = 1'b0;
    w_flash_nxt    = r_flash_idx;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_state_nxt = i_gun_is_connected ? S_G_WAIT : S_M_EVAL;
      end
      S_M_EVAL: begin
        w_state_nxt    = S_RESULT;
        w_enter_result = 1'b1;
        w_res_hit      = w_m_any;
        w_res_idx      = w_m_idx;
      end
      S_G_WAIT: begin
        if (i_new_frame) w_state_nxt = S_G_BLANK;
      end
      S_G_BLANK: begin
        if (i_new_frame) begin
          if (w_photo_any || !w_first_any) begin
            w_state_nxt    = S_RESULT;
            w_enter_result = 1'b1;
          end else begin
            w_state_nxt  = S_G_FLASH;
            w_flash_load = 1'b1;
            w_flash_nxt  = w_first_idx;
          end
        end
      end
      S_G_FLASH: begin
        if (i_new_frame) begin
          if (w_photo_any) begin
            w_state_nxt    = S_RESULT;
            w_enter_result = 1'b1;
            w_res_hit      = 1'b1;
            w_res_idx      = r_flash_idx;
          end else if (w_next_any) begin
            w_flash_load = 1'b1;
            w_flash_nxt  = w_next_idx;
          end else begin
            w_state_nxt    = S_RESULT;
            w_enter_result = 1'b1;
          end
        end
      end
      S_RESULT: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_trig_s1    <= 1'b0;
      r_trig_s2    <= 1'b0;
      r_trig_d     <= 1'b0;
      r_photo_s1   <= 1'b0;
      r_photo_s2   <= 1'b0;
      r_photo_seen <= 1'b0;
      r_mouse_d    <= 1'b0;
      r_shot_fired <= 1'b0;
      r_res_hit    <= 1'b0;
      r_shots_left <= 3'(SHOTS_PER_ROUND);
      r_flash_idx  <= '0;
      r_hit_idx    <= '0;
      r_mx         <= '0;
      r_my         <= '0;
      r_tx         <= '0;
      r_ty         <= '0;
      r_tact       <= '0;
    end else begin
      r_trig_s1    <= i_gun_trigger;
      r_trig_s2    <= r_trig_s1;
      r_trig_d     <= r_trig_s2;
      r_photo_s1   <= i_gun_photodetector;
      r_photo_s2   <= r_photo_s1;
      r_mouse_d    <= i_mouse_left;
      r_state      <= w_state_nxt;
      r_shot_fired <= w_accept;
      if (i_round_start) r_shots_left <= 3'(SHOTS_PER_ROUND);
      else if (w_accept) r_shots_left <= r_shots_left - 3'd1;
      if (w_accept) begin
        r_mx   <= i_mouse_x;
        r_my   <= i_mouse_y;
        r_tx   <= i_target_x;
        r_ty   <= i_target_y;
        r_tact <= i_target_active;
      end
      // Light seen anywhere in the current blank/flash frame; consumed at the frame boundary
      if (i_new_frame) r_photo_seen <= 1'b0;
      else if ((r_state == S_G_BLANK || r_state == S_G_FLASH) && r_photo_s2) r_photo_seen <= 1'b1;
      if (w_flash_load) r_flash_idx <= w_flash_nxt;
      if (w_enter_result) begin
        r_res_hit <= w_res_hit;
        if (w_res_hit) r_hit_idx <= w_res_idx;
      end
    end
  end

  assign o_blank_screen = (r_state == S_G_BLANK);
  assign o_flash_en     = (r_state == S_G_FLASH);
  assign o_flash_idx    = r_flash_idx;
  assign o_busy         = (r_state != S_IDLE);
  assign o_shot_fired   = r_shot_fired;
  assign o_hit          = (r_state == S_RESULT) && r_res_hit;
  assign o_miss         = (r_state == S_RESULT) && !r_res_hit;
  assign o_hit_idx      = r_hit_idx;
  assign o_shots_left   = r_shots_left;

endmodule

// File: doc/ctl_shot_multi.md
# ctl_shot_multi

Shot-resolution controller for N simultaneous ducks. It replaces the single-target mouse hit detector and trigger controller pair. It accepts a shot from either the PS/2 mouse (bounding-box test) or the light gun (NES-style blank-frame and per-target flash sequence), resolves it to at most one target, and reports hit/miss. It also manages per-round ammunition. It sits between the input section (mouse_sync, gun_conn_detector) and the control/draw section (ctl_duck, draw_duck), all in the 65 MHz domain.

## Interface
Parameters:
- N_TARGETS, 2, number of duck slots (1..8)
- TARGET_WIDTH, 64, target box width in pixels
- TARGET_HEIGHT, 48, target box height in pixels
- SHOTS_PER_ROUND, 3, ammo loaded per round (1..7)
- IDX_W, $clog2(N_TARGETS) (min 1), derived, target index width

Ports:
- clk  in  1  65 MHz pixel clock; sole clock
- rst  in  1  synchronous, active-high reset
- new_frame  in  1  one-cycle pulse at start of each VGA frame
- round_start  in  1  one-cycle pulse; reloads ammo
- gun_is_connected  in  1  1 = gun mode, 0 = mouse mode; sampled at shot acceptance
- gun_trigger  in  1  async; active high
- gun_photodetector  in  1  async; high = light seen
- mouse_left  in  1  synchronous button level
- mouse_x, mouse_y  in  10 each  cursor position
- target_x, target_y  in  N_TARGETS*10 each  packed top-left corners; slot i = bits [10i+9:10i]
- target_active  in  N_TARGETS  slot i may be hit
- blank_screen  out  1  draw path renders the whole frame black
- flash_en  out  1  draw path renders box flash_idx white, rest black
- flash_idx  out  IDX_W  target being flashed
- busy  out  1  shot in progress; new shots ignored
- shot_fired  out  1  one-cycle pulse on shot acceptance
- hit  out  1  one-cycle result pulse, target hit
- miss  out  1  one-cycle result pulse, no target hit
- hit_idx  out  IDX_W  index of hit target; held until next hit
- shots_left  out  3  remaining ammo

## Operation
- gun_trigger and gun_photodetector each pass through a 2-FF synchronizer. Trigger and mouse_left use registered rising-edge detection.
- Shot accepted when the edge is present, FSM is IDLE, shots_left != 0, and round_start is low. Acceptance pulses shot_fired and decrements shots_left. Shots failing any condition are dropped silently.
- round_start loads shots_left = SHOTS_PER_ROUND in any state. It does not abort a shot in progress.
- Hit box for slot i: tx <= x < tx+TARGET_WIDTH and ty <= y < ty+TARGET_HEIGHT. Computed in 11 bits, so no wrap at 1023.
- Resolution is lowest-index active matching slot wins. Exactly one of hit/miss pulses per accepted shot.
- FSM states: IDLE, M_EVAL, G_WAIT, G_BLANK, G_FLASH, RESULT.
- Mouse path: IDLE -> M_EVAL (mouse_x/y/target_* registered at acceptance, compare all slots) -> RESULT -> IDLE.
- Gun path: IDLE -> G_WAIT until new_frame -> G_BLANK for one full frame (blank_screen=1).
  - Photodetector high on any cycle of the blank frame sets a cheat flag, meaning the gun is aimed at a light source. At the next new_frame the FSM goes to RESULT with a miss.
  - Otherwise the FSM goes to G_FLASH with flash_idx = lowest active slot. If no slot is active, it goes straight to RESULT with a miss.
- G_FLASH: flash_en=1 for one full frame per active slot, ascending; inactive slots are skipped.
  - Photodetector high on any cycle of the flash frame latches a hit for flash_idx; at the next new_frame the FSM goes to RESULT.
  - If there is no detection, at new_frame the FSM advances to the next active slot, or goes to RESULT with a miss after the last slot.
- target_active is sampled at each new_frame in the gun path. A slot deactivated mid-sequence is skipped.
- A mode change mid-shot has no effect; the mode is latched at acceptance.
- RESULT lasts one cycle: pulses hit (and updates hit_idx) or miss, then returns to IDLE.
- busy = (state != IDLE).

## Timing
- Reset values: state IDLE, shots_left = SHOTS_PER_ROUND, hit_idx = 0, flash_idx = 0, all pulses/flags 0.
- Mouse: mouse_left rises at cycle t (edge visible at t+1) -> shot_fired at t+1 -> hit/miss at t+2.
- Gun: trigger edge reaches acceptance 3 cycles after the pin rises. blank_screen asserts on the cycle after the next new_frame and deasserts on the cycle after the following new_frame.
- Each flash spans exactly one frame. Result arrives one cycle after the new_frame that ends the decisive frame.
- Gun worst-case latency: (N_TARGETS+2) frames.

## Test plan
- Mouse hit: target0 at (100,200) active, cursor (163,247), click -> shot_fired, hit at t+2, hit_idx=0, shots_left 3->2. Cursor (164,247) -> miss.
- Overlap/priority: slots 0 and 1 both cover the cursor, both active -> hit_idx=0. Deactivate slot 0 -> hit_idx=1.
- Ammo: 3 clicks -> shots_left 0; 4th click produces no shot_fired. round_start together with a click -> shots_left=3, click dropped.
- Gun sequence, N=2: trigger, photodetector high only during the slot-1 flash frame -> blank 1 frame, flash_idx 0 then 1, hit with hit_idx=1.
- Gun cheat: photodetector held high throughout -> miss after the blank frame, flash_en never asserted.
- Reset mid-G_FLASH: rst asserted -> next cycle busy=0, flash_en=0, shots_left=3.
